// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a block of RAM words out through a ready/valid port
// Ports: clk, rst_n (async, active-low); start/base_addr/count request a transfer;
//        busy/done report progress; ram_address/ram_wren/ram_q drive a read-latency-RD_LAT RAM;
//        out_valid/out_ready/out_data/out_last form the output stream.
// Optional feature: define RAM_STREAM_READER_CHECKSUM_EN to add a checksum output.
module ram_stream_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int FIFO_D = RD_LAT + 2;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int FILL_W = $clog2(FIFO_D + 1);
    localparam int OCC_W  = 5;
    localparam logic [ADDR_W:0] LEFT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     left_q, left_d;
    logic                iss_q, iss_d, iss_last_q, iss_last_d;
    logic [RD_LAT-1:0]   sr_vld_q, sr_vld_d, sr_last_q, sr_last_d;
    logic [DATA_W-1:0]   fifo_data_q [FIFO_D];
    logic [DATA_W-1:0]   fifo_data_d [FIFO_D];
    logic [FIFO_D-1:0]   fifo_last_q, fifo_last_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                done_q, done_d;
    logic                pop, push, can_issue;
    logic [OCC_W-1:0]    occ;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ram_address = addr_q;
    assign ram_wren    = 1'b0;
    assign out_valid   = (fill_q != '0);
    assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last    = out_valid && fifo_last_q[rd_ptr_q];

    // Credit check: every read already issued (iss_q plus the shift register) and every
    // buffered word owns a FIFO slot; the word leaving this cycle frees its slot early so
    // the stream keeps one word per cycle.
    always_comb begin
        pop  = out_valid && out_ready;
        push = sr_vld_q[RD_LAT-1];
        occ  = OCC_W'(iss_q) + OCC_W'(fill_q) - OCC_W'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + OCC_W'(sr_vld_q[i]);
        end
        can_issue = (occ < OCC_W'(FIFO_D));
    end

    // In-flight tracking and output FIFO; sr stage RD_LAT-1 lines up with ram_q for that read.
    always_comb begin
        sr_vld_d     = '0;
        sr_last_d    = '0;
        sr_vld_d[0]  = iss_q;
        sr_last_d[0] = iss_last_q;
        for (int i = 1; i < RD_LAT; i++) begin
            sr_vld_d[i]  = sr_vld_q[i-1];
            sr_last_d[i] = sr_last_q[i-1];
        end
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = ram_q;
            fifo_last_d[wr_ptr_q] = sr_last_q[RD_LAT-1];
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_D-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_D-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        fill_d = fill_q + FILL_W'(push) - FILL_W'(pop);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        iss_d      = 1'b0;
        iss_last_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        addr_d     = base_addr;
                        left_d     = count - LEFT_ONE;
                        iss_d      = 1'b1;
                        iss_last_d = (count == LEFT_ONE);
                    end
                end
            end
            S_READ: begin
                // left_q counts reads not yet presented; the address wraps naturally.
                if (left_q == '0) begin
                    state_d = S_DRAIN;
                end else if (can_issue) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    left_d     = left_q - LEFT_ONE;
                    iss_d      = 1'b1;
                    iss_last_d = (left_q == LEFT_ONE);
                end
            end
            S_DRAIN: begin
                if (pop && out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            iss_q       <= 1'b0;
            iss_last_q  <= 1'b0;
            sr_vld_q    <= '0;
            sr_last_q   <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            iss_q       <= iss_d;
            iss_last_q  <= iss_last_d;
            sr_vld_q    <= sr_vld_d;
            sr_last_q   <= sr_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            done_q      <= done_d;
        end
    end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_IDLE) && start) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader
module tb_ram_stream_reader;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  base_addr;
    logic [5:0]  count;
    logic        busy, done;
    logic [4:0]  ram_address;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem  [32];
    logic [31:0] pipe [RD_LAT];
    logic [32:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    ram_stream_reader #(.ADDR_W(5), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i * i);
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
        pipe[0] <= mem[ram_address];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_q = pipe[RD_LAT-1];

    // Drives a start pulse; returns at the negedge of the first cycle after it was sampled.
    task automatic do_start(input int base, input int cnt, input bit push_exp);
        logic [32:0] e;
        int a;
        start     = 1'b1;
        base_addr = base[4:0];
        count     = cnt[5:0];
        if (push_exp) begin
            for (int i = 0; i < cnt; i++) begin
                a = (base + i) % 32;
                e = {1'(i == cnt - 1), 32'(a * a)};
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, out_valid, out_last, ram_wren} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, out_valid, out_last, ram_wren});
        end
        total++;
        if ({ram_address, out_data} !== 37'b0) begin
            bad++;
            $display("FAIL reset_data got addr=%0d data=%0d exp=0/0", ram_address, out_data);
        end
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        total++;
        if (checksum !== 32'd0) begin
            bad++; $display("FAIL reset_checksum got=%0d exp=0", checksum);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_full_stream;
        int first_cyc, last_cyc, gaps, ndone, done_cyc, got;
        logic [32:0] e;
        first_cyc = -1; last_cyc = -1; gaps = 0; ndone = 0; done_cyc = -1; got = 0;
        out_ready = 1'b1;
        do_start(0, 31, 1'b1);
        total++;
        if (busy !== 1'b1 || ram_address !== 5'd0) begin
            bad++; $display("FAIL full_first_addr got busy=%b addr=%0d exp=1/0", busy, ram_address);
        end
        for (int cyc = 1; cyc < 200 && (last_cyc < 0 || cyc <= last_cyc + 3); cyc++) begin
            if (done) begin
                ndone++; done_cyc = cyc;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
                total++;
                if (checksum !== 32'd9455) begin
                    bad++; $display("FAIL full_checksum got=%0d exp=9455", checksum);
                end
`endif
            end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL full_extra_word got=%0d exp=none", out_data);
                end else begin
                    e = exp_q.pop_front(); got++;
                    if ({out_last, out_data} !== e) begin
                        bad++; $display("FAIL full_word%0d got=%h exp=%h", got, {out_last, out_data}, e);
                    end
                    if (e[32]) last_cyc = cyc;
                end
            end else if (first_cyc >= 0 && last_cyc < 0) begin
                gaps++;
            end
            @(negedge clk);
        end
        total++;
        if (first_cyc != RD_LAT + 2) begin
            bad++; $display("FAIL full_latency got=%0d exp=%0d", first_cyc, RD_LAT + 2);
        end
        total++;
        if (gaps != 0 || got != 31) begin
            bad++; $display("FAIL full_throughput got gaps=%0d words=%0d exp=0/31", gaps, got);
        end
        total++;
        if (ndone != 1 || done_cyc != last_cyc + 1 || busy !== 1'b0) begin
            bad++; $display("FAIL full_done got n=%0d at=%0d busy=%b exp=1 at %0d busy=0", ndone, done_cyc, busy, last_cyc + 1);
        end
    endtask

    task automatic test_backpressure;
        int first_cyc, got, ndone, n, nstable;
        logic [32:0] e, hold;
        bit have_hold;
        first_cyc = -1; got = 0; ndone = 0; have_hold = 0; nstable = 0;
        out_ready = 1'b0;
        do_start(0, 8, 1'b1);
        for (int cyc = 1; cyc < 300 && got < 8; cyc++) begin
            if (done) ndone++;
            if (have_hold) begin
                total++; nstable++;
                if ({out_valid, out_last, out_data} !== {1'b1, hold}) begin
                    bad++; $display("FAIL bp_stable got=%b_%h exp=1_%h", out_valid, {out_last, out_data}, hold);
                end
            end
            have_hold = out_valid && !out_ready;
            hold = {out_last, out_data};
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_word got=%0d exp=none", out_data);
                end else begin
                    e = exp_q.pop_front(); got++;
                    if ({out_last, out_data} !== e) begin
                        bad++; $display("FAIL bp_word%0d got=%h exp=%h", got, {out_last, out_data}, e);
                    end
                end
            end
            @(negedge clk);
            n = cyc + 1 - first_cyc;
            out_ready = (first_cyc >= 0) && (n >= 10) && ((n - 10) % 2 == 0);
        end
        out_ready = 1'b1;
        repeat (2) begin
            if (done) ndone++;
            @(negedge clk);
        end
        total++;
        if (got != 8 || ndone != 1 || out_valid !== 1'b0 || nstable < 10) begin
            bad++; $display("FAIL bp_summary got words=%0d done=%0d valid=%b stalls=%0d exp=8/1/0/>=10", got, ndone, out_valid, nstable);
        end
    endtask

    task automatic test_wrap;
        int got;
        logic [32:0] e;
        got = 0;
        out_ready = 1'b1;
        do_start(30, 4, 1'b1);
        for (int cyc = 1; cyc < 50 && got < 4; cyc++) begin
            if (out_valid) begin
                total++;
                e = exp_q.pop_front(); got++;
                if ({out_last, out_data} !== e) begin
                    bad++; $display("FAIL wrap_word%0d got=%h exp=%h", got, {out_last, out_data}, e);
                end
            end
            @(negedge clk);
        end
        total++;
        if (got != 4 || done !== 1'b1) begin
            bad++; $display("FAIL wrap_end got words=%0d done=%b exp=4/1", got, done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_and_busy;
        int nv, nd, got, extra;
        logic [32:0] e;
        nv = 0; nd = 0; got = 0; extra = 0;
        out_ready = 1'b1;
        do_start(7, 0, 1'b0);
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL zero_done got done=%b valid=%b exp=1/0", done, out_valid);
        end
        repeat (5) begin
            @(negedge clk);
            if (out_valid) nv++;
            if (done) nd++;
        end
        total++;
        if (nv != 0 || nd != 0) begin
            bad++; $display("FAIL zero_quiet got valids=%0d dones=%0d exp=0/0", nv, nd);
        end
        out_ready = 1'b0;
        do_start(5, 3, 1'b1);
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_mid got=%b exp=1", busy);
        end
        do_start(0, 10, 1'b0);
        out_ready = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) nd++;
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    extra++; bad++; $display("FAIL busy_extra_word got=%0d exp=none", out_data);
                end else begin
                    e = exp_q.pop_front(); got++;
                    if ({out_last, out_data} !== e) begin
                        bad++; $display("FAIL busy_word%0d got=%h exp=%h", got, {out_last, out_data}, e);
                    end
                end
            end
            @(negedge clk);
        end
        total++;
        if (got != 3 || nd != 1 || ram_address !== 5'd7 || busy !== 1'b0) begin
            bad++; $display("FAIL busy_ignore got words=%0d done=%0d addr=%0d busy=%b exp=3/1/7/0", got, nd, ram_address, busy);
        end
    endtask

    task automatic test_reset_mid;
        int got;
        logic [32:0] e;
        got = 0;
        out_ready = 1'b1;
        do_start(0, 20, 1'b1);
        for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
            if (out_valid) begin
                e = exp_q.pop_front(); got++;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, out_valid, out_last, ram_address, out_data} !== 41'b0) begin
            bad++; $display("FAIL midreset_outputs got busy=%b valid=%b last=%b addr=%0d data=%0d exp=all 0", busy, out_valid, out_last, ram_address, out_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_start(3, 2, 1'b1);
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
            if (out_valid) begin
                total++;
                e = exp_q.pop_front(); got++;
                if ({out_last, out_data} !== e) begin
                    bad++; $display("FAIL postreset_word%0d got=%h exp=%h", got, {out_last, out_data}, e);
                end
            end
            @(negedge clk);
        end
        total++;
        if (got != 2 || done !== 1'b1) begin
            bad++; $display("FAIL postreset_end got words=%0d done=%b exp=2/1", got, done);
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_backpressure();
        test_wrap();
        test_zero_and_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from ram_address to valid ram_q (1..4).
REQ-004 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin transfer; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_W  first RAM address, sampled with start.
REQ-008 SHALL have port count  input  ADDR_W+1  words to read (0..2^ADDR_W), sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ram_address  output  ADDR_W  read address to the RAM read port.
REQ-012 SHALL have port ram_wren  output  1  constant 0.
REQ-013 SHALL have port ram_q  input  DATA_W  RAM read data.
REQ-014 SHALL have port out_valid  output  1  out_data holds a word.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-016 SHALL have port out_data  output  DATA_W  streamed word.
REQ-017 SHALL have port out_last  output  1  marks the final word of a transfer.

Function
REQ-018 SHALL implement FSM IDLE -> READ (start, count>0) -> DRAIN (all reads issued) -> IDLE (last word accepted); IDLE -> IDLE with done pulse when start and count==0.
REQ-019 SHALL present the first read address the cycle after start is sampled; subsequent addresses base_addr+i mod 2^ADDR_W (wrap 31 -> 0 at default width).
REQ-020 SHALL track in-flight reads with an RD_LAT-deep valid/last shift register and capture ram_q into an output FIFO of depth RD_LAT+2 exactly RD_LAT cycles after issue.
REQ-021 SHALL issue a read only when in-flight count plus FIFO occupancy < RD_LAT+2, so no word is ever dropped.
REQ-022 SHALL sustain one word per cycle while out_ready is held high; first out_valid occurs RD_LAT+1 cycles after the address is presented.
REQ-023 SHALL transfer a word only on out_valid && out_ready; while out_valid && !out_ready, out_data and out_last SHALL be held stable.
REQ-024 SHALL assert out_last with exactly the count-th word.
REQ-025 SHALL assert done for one cycle in the cycle after the last word is transferred, and deassert busy in that same cycle.
REQ-026 SHALL ignore start while busy; no parameter or transfer change.
REQ-027 SHALL hold ram_address at its last value when no read is issued.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-transfer, immediately enter IDLE, flush FIFO and in-flight tracking, and drive busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_address=0.
REQ-029 SHALL accept a new start in the first clock edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro RAM_STREAM_READER_CHECKSUM_EN defined, add output checksum (DATA_W): sum mod 2^DATA_W of all transferred words, cleared on accepted start, stable from done until the next start; reset value 0.
REQ-031 SHALL, without RAM_STREAM_READER_CHECKSUM_EN, omit the checksum port and its logic, with all other behaviour unchanged.

Verification (RAM preloaded with i*i at address i, RD_LAT=2)
REQ-032 SHALL cover: base 0, count 31, out_ready=1 -> 0,1,4,...,900 in order, one per cycle, out_last with 900, single done pulse.
REQ-033 SHALL cover: base 0, count 8, out_ready low for 10 cycles after the first valid, then toggling -> exactly 0,1,4,...,49, no loss or duplication, data stable while stalled.
REQ-034 SHALL cover: base 30, count 4 -> 900, 961, 0, 1 (address wrap); out_last on 1.
REQ-035 SHALL cover: count 0 -> done the next cycle, out_valid never high; start while busy -> ignored.
REQ-036 SHALL cover: rst_n pulled low after 5 of 20 words -> all outputs at reset values; then base 3, count 2 -> 9, 16.
REQ-037 SHALL cover, with RAM_STREAM_READER_CHECKSUM_EN: base 0, count 31 -> checksum 9455 at done.
